// File: rtl/pipe_trace_buffer_pkg.sv
// Shared encodings and helpers for the retire-trace recorder.
// Record layout, MSB first: {cycle, pc, wb_en, wb_addr, wb_data}.
package pipe_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAPT = 3'd1,
        ST_POST = 3'd2,
        ST_DONE = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_FREE = 2'd0,
        MODE_FILL = 2'd1,
        MODE_TRIG = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int OVF_W = 16;

    function automatic int rec_width(input int xlen, input int raw, input int cycw);
        return cycw + xlen + 1 + raw + xlen;
    endfunction

    function automatic int wb_width(input int xlen, input int raw);
        return 1 + raw + xlen;
    endfunction

    // Reserved encoding falls back to free-running capture.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_FREE : mode_e'(m);
    endfunction

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Trace storage: synchronous write, combinational read.
// The array carries no reset; validity is tracked by the occupancy count.
module trace_ram
    import pipe_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Retire-trace recorder: one record per WB-valid cycle into a circular
// buffer, with free-run, fill-once and PC-triggered capture, drained oldest-first.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NSTAGE = 5,
    parameter int DEPTH  = 64,
    parameter int CYCW   = 32,
    parameter int RAW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSTAGE*XLEN-1:0]   stage_pc,
    input  logic [NSTAGE-1:0]        stage_valid,
    input  logic                     wb_en,
    input  logic [RAW-1:0]           wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     arm,
    input  logic [1:0]               mode,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [$clog2(DEPTH):0]   post_cnt,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CYCW-1:0]          rd_cyc,
    output logic [XLEN-1:0]          rd_pc,
    output logic [RAW+XLEN:0]        rd_wb,
    output logic [2:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = rec_width(XLEN, RAW, CYCW);
    localparam int WBW = wb_width(XLEN, RAW);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [XLEN-1:0]   trig_q, trig_d;
    logic [CW-1:0]     post_q, post_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic [CYCW-1:0]   cyc_q, cyc_d;

    logic              retire;
    logic [XLEN-1:0]   wb_pc;
    logic              full;
    logic              trig_hit;
    logic              do_wr;
    logic              do_rd;
    logic              drop;
    logic              ovr;
    logic              inc;
    logic [RW-1:0]     wr_rec;
    logic [RW-1:0]     rd_rec;
    logic [CYCW-1:0]   rec_cyc;
    logic [XLEN-1:0]   rec_pc;
    logic [WBW-1:0]    rec_wb;
    logic              unused_taps;

    assign retire   = stage_valid[NSTAGE-1];
    assign wb_pc    = stage_pc[(NSTAGE-1)*XLEN +: XLEN];
    assign full     = (count_q == FULL_CNT);
    assign trig_hit = (wb_pc == trig_q);
    assign rd_valid = (count_q != '0);
    assign wr_rec   = {cyc_q, wb_pc, wb_en, wb_addr, wb_data};
    assign unused_taps = ^{stage_pc, stage_valid};

    // A handshake coinciding with arm is discarded along with the buffer.
    assign do_rd = rd_valid && rd_ready && !arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_CAPT;
        end else begin
            case (state_q)
                ST_CAPT: begin
                    if (do_wr && mode_q == MODE_FILL && count_d == FULL_CNT) begin
                        state_d = ST_DONE;
                    end
                    if (do_wr && mode_q == MODE_TRIG && trig_hit) begin
                        state_d = (post_q <= CW'(1)) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (do_wr && rem_q <= CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        do_wr = 1'b0;
        drop  = 1'b0;
        if (!arm) begin
            case (state_q)
                ST_CAPT: begin
                    if (retire) begin
                        if (mode_q == MODE_FILL && full) begin
                            drop = 1'b1;
                        end else begin
                            do_wr = 1'b1;
                        end
                    end
                end
                ST_POST: do_wr = retire;
                default: ;
            endcase
        end
    end

    // Writing into a full ring without a read evicts the oldest record.
    assign ovr = do_wr && full && !do_rd;
    assign inc = do_wr && !ovr;

    always_comb begin
        cyc_d    = cyc_q + 1'b1;
        mode_d   = mode_q;
        trig_d   = trig_q;
        post_d   = post_q;
        rem_d    = rem_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (arm) begin
            mode_d   = norm_mode(mode);
            trig_d   = trig_pc;
            post_d   = post_cnt;
            rem_d    = '0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_rd || ovr) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({inc, do_rd})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (ovr || drop) begin
                ovf_d = sat_inc(ovf_q);
            end
            if (state_q == ST_CAPT && do_wr && mode_q == MODE_TRIG && trig_hit) begin
                rem_d = post_q - 1'b1;
            end else if (state_q == ST_POST && do_wr) begin
                rem_d = rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= '0;
            mode_q   <= MODE_FREE;
            trig_q   <= '0;
            post_q   <= '0;
            rem_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            cyc_q    <= cyc_d;
            mode_q   <= mode_d;
            trig_q   <= trig_d;
            post_q   <= post_d;
            rem_q    <= rem_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr_q),
        .wdata (wr_rec),
        .raddr (rd_ptr_q),
        .rdata (rd_rec)
    );

    assign {rec_cyc, rec_pc, rec_wb} = rd_rec;

    // Gate the uninitialised array so an empty buffer presents zeros.
    assign rd_cyc   = rd_valid ? rec_cyc : '0;
    assign rd_pc    = rd_valid ? rec_pc  : '0;
    assign rd_wb    = rd_valid ? rec_wb  : '0;
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer at DEPTH=8.
// Stimulus pushes the records expected to drain; a monitor pops on each transfer.
module tb_pipe_trace_buffer;

    localparam int XLEN   = 32;
    localparam int NSTAGE = 5;
    localparam int DEPTH  = 8;
    localparam int CYCW   = 32;
    localparam int RAW    = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [CYCW-1:0]     cyc;
        logic [XLEN-1:0]     pc;
        logic [RAW+XLEN:0]   wb;
    } rec_t;

    logic                     clk;
    logic                     rst;
    logic [NSTAGE*XLEN-1:0]   stage_pc;
    logic [NSTAGE-1:0]        stage_valid;
    logic                     wb_en;
    logic [RAW-1:0]           wb_addr;
    logic [XLEN-1:0]          wb_data;
    logic                     arm;
    logic [1:0]               mode;
    logic [XLEN-1:0]          trig_pc;
    logic [CW-1:0]            post_cnt;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [CYCW-1:0]          rd_cyc;
    logic [XLEN-1:0]          rd_pc;
    logic [RAW+XLEN:0]        rd_wb;
    logic [2:0]               state;
    logic [CW-1:0]            count;
    logic [15:0]              overflow;

    int   checks = 0;
    int   errors = 0;
    rec_t sb[$];
    rec_t mon_r;
    logic [CYCW-1:0] cyc_model;

    pipe_trace_buffer #(
        .XLEN   (XLEN),
        .NSTAGE (NSTAGE),
        .DEPTH  (DEPTH),
        .CYCW   (CYCW),
        .RAW    (RAW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stage_pc    (stage_pc),
        .stage_valid (stage_valid),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .arm         (arm),
        .mode        (mode),
        .trig_pc     (trig_pc),
        .post_cnt    (post_cnt),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_cyc      (rd_cyc),
        .rd_pc       (rd_pc),
        .rd_wb       (rd_wb),
        .state       (state),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected cycle stamp: edges seen since reset was released.
    always @(posedge clk) begin
        if (rst) cyc_model <= '0;
        else     cyc_model <= cyc_model + 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready && !arm) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got pc %0h, required no record", rd_pc);
            end else begin
                mon_r = sb.pop_front();
                if ({rd_cyc, rd_pc, rd_wb} !== {mon_r.cyc, mon_r.pc, mon_r.wb}) begin
                    errors++;
                    $display("FAIL rd_record: got cyc %0d pc %0h wb %0h, required cyc %0d pc %0h wb %0h",
                             rd_cyc, rd_pc, rd_wb, mon_r.cyc, mon_r.pc, mon_r.wb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_pc(input logic [XLEN-1:0] pc);
        for (int s = 0; s < NSTAGE; s++) begin
            stage_pc[s*XLEN +: XLEN] = pc + 32'(4 * (NSTAGE - 1 - s));
        end
        wb_en   = pc[2];
        wb_addr = pc[5:2];
        wb_data = pc ^ 32'hA5A5_0000;
    endtask

    task automatic retire(input logic [XLEN-1:0] pc, input bit keep);
        rec_t r;
        set_pc(pc);
        stage_valid = '1;
        if (keep) begin
            r.cyc = cyc_model;
            r.pc  = pc;
            r.wb  = {pc[2], pc[5:2], pc ^ 32'hA5A5_0000};
            sb.push_back(r);
        end
        tick();
    endtask

    task automatic idle();
        stage_valid = '0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [XLEN-1:0] tpc,
                          input logic [CW-1:0] pcnt);
        mode     = m;
        trig_pc  = tpc;
        post_cnt = pcnt;
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rd_ready = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d records left, required 0", name, sb.size());
            sb.delete();
        end
        chk({name, "_count_empty"}, 64'(count), 64'd0);
        chk({name, "_valid_low"}, 64'(rd_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        stage_pc = '0;
        stage_valid = '1;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        arm = 1'b0;
        mode = 2'd0;
        trig_pc = '0;
        post_cnt = '0;
        rd_ready = 1'b0;
        set_pc(32'h40);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_valid", 64'(rd_valid), 64'd0);
            chk("rst_state", 64'(state), 64'd0);
        end
        chk("rst_pc", 64'(rd_pc), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_no_write", 64'(count), 64'd0);
        chk("idle_state", 64'(state), 64'd0);
        idle();
        tick();

        // FILL: ten retires, only the first eight are kept.
        do_arm(2'd1, '0, '0);
        chk("fill_armed", 64'(state), 64'd1);
        for (int i = 0; i < 10; i++) begin
            retire(32'(i * 4), i < 8);
        end
        idle();
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_state", 64'(state), 64'd3);
        chk("fill_ovf", 64'(overflow), 64'd0);
        drain("fill");
        chk("fill_done_after", 64'(state), 64'd3);

        // FREE: twelve retires, four oldest overwritten.
        do_arm(2'd0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            retire(32'(i * 4), i >= 4);
        end
        idle();
        chk("free_count", 64'(count), 64'd8);
        chk("free_ovf", 64'(overflow), 64'd4);
        chk("free_state", 64'(state), 64'd1);
        drain("free");

        // TRIG on 0x18 with three post records (trigger inclusive).
        do_arm(2'd2, 32'h18, CW'(3));
        for (int i = 0; i < 16; i++) begin
            retire(32'(i * 4), i >= 1 && i <= 8);
            if (i == 6) chk("trig_post", 64'(state), 64'd2);
            if (i == 7) chk("trig_post2", 64'(state), 64'd2);
            if (i == 8) chk("trig_done", 64'(state), 64'd3);
        end
        idle();
        chk("trig_count", 64'(count), 64'd8);
        chk("trig_ovf", 64'(overflow), 64'd1);
        chk("trig_state", 64'(state), 64'd3);
        drain("trig");

        // Full ring with simultaneous read and write every cycle.
        do_arm(2'd0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            retire(32'h100 + 32'(i * 4), 1'b1);
        end
        chk("conc_full", 64'(count), 64'd8);
        rd_ready = 1'b1;
        for (int i = 8; i < 14; i++) begin
            retire(32'h100 + 32'(i * 4), 1'b1);
            chk("conc_count", 64'(count), 64'd8);
            chk("conc_ovf", 64'(overflow), 64'd0);
        end
        idle();
        drain("conc");

        // arm while draining discards contents and pending handshake.
        do_arm(2'd0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            retire(32'h200 + 32'(i * 4), i >= 2);
        end
        idle();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_ready = 1'b0;
        chk("mid_count5", 64'(count), 64'd5);
        chk("mid_ovf2", 64'(overflow), 64'd2);
        rd_ready = 1'b1;
        do_arm(2'd0, '0, '0);
        rd_ready = 1'b0;
        sb.delete();
        chk("rearm_count", 64'(count), 64'd0);
        chk("rearm_valid", 64'(rd_valid), 64'd0);
        chk("rearm_state", 64'(state), 64'd1);
        chk("rearm_ovf", 64'(overflow), 64'd0);
        tick();

        chk("sb_leftover", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable, parametrised retire-trace recorder for the TinyRISC pipeline.
- Replaces ad-hoc per-cycle stage printing in benches with an on-chip circular trace memory.
- Captures one record per retiring instruction (WB stage valid). Supports free-run, fill-once and PC-triggered capture with post-trigger count.
- Drained oldest-first over a valid/ready read port. Sits beside TinyRISC_Pipeline and taps the stage PCs and the WB write port.

Parameters:
- XLEN, 32, datapath/PC width
- NSTAGE, 5, pipeline stages tapped (stage 0 = fetch, NSTAGE-1 = WB)
- DEPTH, 64, trace entries (power of two, >=4)
- CYCW, 32, cycle-stamp width
- RAW, 4, register address width

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- stage_pc  in  NSTAGE*XLEN  per-stage PC, stage i at bits [i*XLEN +: XLEN]
- stage_valid  in  NSTAGE  per-stage valid (non-bubble)
- wb_en  in  1  register-file write enable
- wb_addr  in  RAW  write address
- wb_data  in  XLEN  write data
- arm  in  1  single-cycle pulse: clear buffer, start capture
- mode  in  2  0=FREE, 1=FILL, 2=TRIG, 3=reserved (treated as FREE)
- trig_pc  in  XLEN  trigger PC (TRIG mode, matched at WB stage)
- post_cnt  in  $clog2(DEPTH)+1  records captured after trigger, inclusive of trigger record
- rd_valid  out  1  record available
- rd_ready  in  1  consumer accepts record
- rd_cyc  out  CYCW  cycle stamp
- rd_pc  out  XLEN  retiring PC
- rd_wb  out  1+RAW+XLEN  {wb_en, wb_addr, wb_data}
- state  out  3  current FSM state
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  16  records dropped/overwritten, saturating

Behaviour:
- Reset: state=IDLE, count=0, rd_valid=0, rd_* outputs=0, overflow=0, cycle counter=0, pointers=0. Reset mid-capture discards all contents.
- Cycle counter increments every non-reset cycle and wraps at 2^CYCW.
- Retire event: stage_valid[NSTAGE-1]=1. Record = {cycle, stage_pc[WB], wb_en, wb_addr, wb_data}, sampled the same cycle and written at the next edge. Write latency 1 cycle. rd_valid rises the cycle after the first write.
- FSM states: IDLE(0), CAPT(1), POST(2), DONE(3).
  - IDLE: no writes. arm clears pointers, count and overflow, latches mode, trig_pc and post_cnt, then -> CAPT.
  - CAPT, FREE: every retire is written. When full, overwrite oldest: read pointer advances and overflow increments. Never leaves CAPT except on arm (restart) or rst.
  - CAPT, FILL: write until count==DEPTH, then -> DONE. Retires while full are dropped and increment overflow; these cannot occur in CAPT since the full transition is immediate.
  - CAPT, TRIG: writes as in FREE (pre-trigger history). A retire with stage_pc[WB]==trig_pc is written. If post_cnt<=1 -> DONE, else -> POST with remaining=post_cnt-1.
  - POST: writes continue, overwriting as in FREE. remaining decrements per retire and -> DONE when it reaches 0. post_cnt=0 behaves as 1.
  - DONE: no writes, drain only. arm -> CAPT (restart).
- Read: the record at the read pointer is presented when count>0. A transfer occurs when rd_valid&&rd_ready. rd_* are stable while rd_valid&&!rd_ready. Drain is legal in every state.
- Simultaneous write and read:
  - Not full: count unchanged, both pointers advance.
  - Full, ring modes: read and overwrite are coincident; count stays DEPTH and overflow does not increment.
- arm while rd_valid: buffer clears. rd_valid drops next cycle and no partial handshake is honoured.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately to distinguish full from empty.
- overflow saturates at 16'hFFFF.

Decomposition:
- Package pipe_trace_pkg: mode encodings, state encodings, record field widths, pack/unpack helpers.
- Sub-module trace_ram: simple dual-port RAM, DEPTH x (CYCW+XLEN+1+RAW+XLEN), synchronous write, combinational read, no reset on array.
- Top holds the FSM, pointers, counters and trigger compare.

Test Plan:
- Reset then idle: rst high 3 cycles, retires present -> count=0, rd_valid=0, state=IDLE throughout.
- FILL, DEPTH=8, arm then 10 consecutive retires with PCs 0x0,0x4..0x24, rd_ready=0 -> count=8, state=DONE, overflow=0. Drain yields PCs 0x0..0x1C in order with cycle stamps strictly increasing by 1.
- FREE overwrite, DEPTH=8, 12 retires with PCs 0x0..0x2C -> count=8, overflow=4. Drain yields 0x10..0x2C.
- TRIG, trig_pc=0x18, post_cnt=3, retires 0x0..0x3C -> DONE after PC 0x20 is written. Drain yields the last 8 records ending 0x18,0x1C,0x20. PCs 0x24+ are not recorded.
- Concurrent read/write, full buffer in FREE, rd_ready=1 every cycle with a retire every cycle -> count stays 8, overflow unchanged, rd_pc increments by 4 per cycle.
- arm mid-drain with count=5 -> next cycle count=0, rd_valid=0, state=CAPT, overflow=0.
